bird_ctrl: RTL and testbench
============================

BIRD_CTRL -- requirements
Module: bird_ctrl

Interface
REQ-001 SHALL have parameter BIRD_Y, default 10'd300: top row of the bird sprite on screen.
REQ-002 SHALL have parameter X_START, default 11'd640: left-edge x loaded on spawn.
REQ-003 SHALL have parameter SPEED, default 11'd4: pixels moved left per tick.
REQ-004 SHALL have parameter FLAP_TICKS, default 8: ticks per animation frame.
REQ-005 SHALL have port clk, input, 1: single system clock; all state on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port tick, input, 1: one-cycle game-frame pulse.
REQ-008 SHALL have port run, input, 1: game running; low freezes motion and animation.
REQ-009 SHALL have port spawn, input, 1: one-cycle request to launch a bird.
REQ-010 SHALL have port pix_x, input, 10: current VGA pixel column.
REQ-011 SHALL have port pix_y, input, 10: current VGA pixel row.
REQ-012 SHALL have port rom_addr, output, 12: sprite ROM address.
REQ-013 SHALL have port rom_data, input, 50: combinational sprite ROM row data.
REQ-014 SHALL have port bird_on, output, 1: registered pixel-hit flag.
REQ-015 SHALL have port bird_x, output, 11: current left-edge x.
REQ-016 SHALL have port active, output, 1: high while a bird is on screen.
REQ-017 SHALL have port done, output, 1: one-cycle pulse when the bird leaves the screen.

Function
REQ-018 SHALL implement FSM states IDLE, FLY and FREEZE.
REQ-019 IDLE->FLY SHALL occur on spawn&&run, loading bird_x=X_START, frame=0 and flap count=0; spawn in FLY or FREEZE SHALL be ignored.
REQ-020 In FLY on tick, if bird_x<SPEED: bird_x SHALL become 0, next state IDLE, and done SHALL pulse for exactly one cycle; otherwise bird_x SHALL become bird_x-SPEED.
REQ-021 FLY->FREEZE SHALL occur when run=0; FREEZE->FLY SHALL occur when run=1; in FREEZE, bird_x, frame and flap count SHALL hold, and ticks SHALL be ignored.
REQ-022 If run=0 and tick occur in the same FLY cycle, FREEZE SHALL win and there SHALL be no move.
REQ-023 If tick and spawn coincide in IDLE, spawn SHALL win and there SHALL be no move that cycle.
REQ-024 On each FLY tick that does not end the flight, the flap counter SHALL increment; at FLAP_TICKS-1 it SHALL wrap to 0 and toggle frame.
REQ-025 active SHALL be 1 in FLY and FREEZE, and 0 in IDLE.
REQ-026 Window SHALL be: active && BIRD_Y<=pix_y<=BIRD_Y+38 && bird_x<=pix_x<=bird_x+49, compared at 11 bits, with no wrap.
REQ-027 rom_addr SHALL be combinational: {3'b000, frame, row[7:0]} with row=pix_y-BIRD_Y when in window; otherwise 12'h000.
REQ-028 bird_on SHALL register window && rom_data[49-(pix_x-bird_x)], giving 1-cycle latency from pix_x/pix_y.
REQ-029 Column 0 of the sprite SHALL map to rom_data bit 49 (MSB = leftmost pixel).

Reset
REQ-030 rst SHALL force, asynchronously: state=IDLE, bird_x=0, frame=0, flap count=0, bird_on=0, done=0, active=0.
REQ-031 rst asserted mid-flight SHALL abort the flight without a done pulse; spawn SHALL be honoured on the first clock after deassertion.

Configuration
REQ-032 With macro BIRD_FLAP_EN defined, frame SHALL toggle per REQ-024.
REQ-033 Without BIRD_FLAP_EN, frame SHALL be constant 0, the flap counter SHALL be omitted, and rom_addr bit 8 SHALL always be 0.

Verification
REQ-034 The bench SHALL cover: rst=1 mid-FLY -> same cycle active=0, bird_x=0, bird_on=0; no done pulse.
REQ-035 The bench SHALL cover: spawn with run=1 -> next cycle active=1, bird_x=640; 10 ticks -> bird_x=600.
REQ-036 The bench SHALL cover: bird_x=3, SPEED=4, tick -> bird_x=0, IDLE, done high exactly 1 cycle.
REQ-037 The bench SHALL cover, with BIRD_FLAP_EN: 8 ticks -> rom_addr[8]=1; 16 ticks -> 0. Without the macro: rom_addr[8] stays 0.
REQ-038 The bench SHALL cover: bird_x=100, pix_y=301, pix_x=122, rom_data bit 27=1 -> rom_addr=12'h001 and bird_on=1 one cycle later; pix_x=150 -> bird_on=0.
REQ-039 The bench SHALL cover: run=0 with tick in FLY -> bird_x unchanged; spawn ignored; run=1 -> motion resumes from the held bird_x.

Source files
------------

// File: rtl/bird_ctrl.sv
// Bird sprite controller: spawns, scrolls left per tick, renders via sprite ROM.
// Optional wing-flap animation enabled with macro BIRD_FLAP_EN (default build: frame fixed at 0).
module bird_ctrl #(
    parameter logic [9:0]  BIRD_Y     = 10'd300,
    parameter logic [10:0] X_START    = 11'd640,
    parameter logic [10:0] SPEED      = 11'd4,
    parameter int          FLAP_TICKS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        run,
    input  logic        spawn,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    output logic [11:0] rom_addr,
    input  logic [49:0] rom_data,
    output logic        bird_on,
    output logic [10:0] bird_x,
    output logic        active,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, FLY, FREEZE} state_t;

    state_t      state, state_nxt;
    logic [10:0] bx, bx_nxt;
    logic        done_nxt;
    logic        frame;

    // A tick that moves the bird without ending the flight; drives the flap counter.
    logic        move_tick;
    logic        launch;

    assign launch    = (state == IDLE) && spawn && run;
    assign move_tick = (state == FLY) && run && tick && (bx >= SPEED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            bx    <= 11'd0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            bx    <= bx_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bx_nxt    = bx;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (spawn && run) begin
                    state_nxt = FLY;
                    bx_nxt    = X_START;
                end
            end
            FLY: begin
                // Freeze takes priority over a coincident tick.
                if (!run) begin
                    state_nxt = FREEZE;
                end else if (tick) begin
                    if (bx < SPEED) begin
                        bx_nxt    = 11'd0;
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        bx_nxt = bx - SPEED;
                    end
                end
            end
            FREEZE: begin
                if (run) state_nxt = FLY;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef BIRD_FLAP_EN
    localparam int FW = (FLAP_TICKS > 1) ? $clog2(FLAP_TICKS) : 1;

    logic [FW-1:0] flap, flap_nxt;
    logic          frame_q, frame_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flap    <= '0;
            frame_q <= 1'b0;
        end else begin
            flap    <= flap_nxt;
            frame_q <= frame_nxt;
        end
    end

    always_comb begin
        flap_nxt  = flap;
        frame_nxt = frame_q;
        if (launch) begin
            flap_nxt  = '0;
            frame_nxt = 1'b0;
        end else if (move_tick) begin
            if (flap == FW'(FLAP_TICKS - 1)) begin
                flap_nxt  = '0;
                frame_nxt = ~frame_q;
            end else begin
                flap_nxt = flap + 1'b1;
            end
        end
    end

    assign frame = frame_q;
`else
    assign frame = 1'b0;
`endif

    // Window compare is done one bit wider than the pixel counters so bird_x+49 never wraps.
    logic [11:0] x_hi;
    logic [10:0] y_lo, y_hi;
    logic        win;
    logic [7:0]  row;
    logic [5:0]  col;
    logic [5:0]  bit_idx;
    logic        pix_hit;

    assign x_hi = {1'b0, bx} + 12'd49;
    assign y_lo = {1'b0, BIRD_Y};
    assign y_hi = y_lo + 11'd38;

    assign win = active
              && ({1'b0, pix_y} >= y_lo) && ({1'b0, pix_y} <= y_hi)
              && ({1'b0, pix_x} >= bx)   && ({2'b00, pix_x} <= x_hi);

    // Only the low bits of the offsets matter inside the window.
    assign row     = pix_y[7:0] - BIRD_Y[7:0];
    assign col     = pix_x[5:0] - bx[5:0];
    assign bit_idx = 6'd49 - col;

    assign rom_addr = win ? {3'b000, frame, row} : 12'h000;
    assign pix_hit  = win && rom_data[bit_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bird_on <= 1'b0;
        else     bird_on <= pix_hit;
    end

    assign bird_x = bx;
    assign active = (state != IDLE);

endmodule

// File: tb/tb_bird_ctrl.sv
// Directed bench for bird_ctrl: expectations queued at stimulus time, checked by a negedge monitor.
module tb_bird_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0, run = 1'b0, spawn = 1'b0;
    logic [9:0]  pix_x = '0, pix_y = '0;
    logic [49:0] rom_data = '0;
    logic [11:0] rom_addr, o_rom_addr;
    logic        bird_on, active, done, o_bird_on, o_active, o_done;
    logic [10:0] bird_x, o_bird_x;

    bird_ctrl dut (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .spawn(spawn),
        .pix_x(pix_x), .pix_y(pix_y), .rom_addr(rom_addr), .rom_data(rom_data),
        .bird_on(bird_on), .bird_x(bird_x), .active(active), .done(done)
    );

    // Second instance starts 3 px off the 4-px grid so it reaches bird_x=3 before exiting.
    bird_ctrl #(.X_START(11'd643)) dut_odd (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .spawn(spawn),
        .pix_x(pix_x), .pix_y(pix_y), .rom_addr(o_rom_addr), .rom_data(rom_data),
        .bird_on(o_bird_on), .bird_x(o_bird_x), .active(o_active), .done(o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          sig;
        logic [11:0] val;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_x, exp_ox, n_mv;

    localparam int S_ACT = 0, S_BX = 1, S_ON = 2, S_RA = 3, S_DONE = 4;
    localparam int S_OACT = 5, S_OBX = 6, S_ODONE = 7;

    function automatic logic [11:0] get_sig(input int s);
        case (s)
            S_ACT:   return {11'd0, active};
            S_BX:    return {1'b0, bird_x};
            S_ON:    return {11'd0, bird_on};
            S_RA:    return rom_addr;
            S_DONE:  return {11'd0, done};
            S_OACT:  return {11'd0, o_active};
            S_OBX:   return {1'b0, o_bird_x};
            default: return {11'd0, o_done};
        endcase
    endfunction

    function automatic logic fr();
`ifdef BIRD_FLAP_EN
        return ((n_mv / 8) % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [11:0] ra(input logic [7:0] row);
        return {3'b000, fr(), row};
    endfunction

    task automatic exp_push(input int d, input int s, input logic [11:0] v, input string nm);
        exp_t e;
        e.cyc = cyc + d;
        e.sig = s;
        e.val = v;
        e.nm  = nm;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tk(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
            exp_x  = exp_x - 4;
            exp_ox = exp_ox - 4;
            n_mv++;
        end
    endtask

    // Monitor: compares every queued expectation due this cycle; any done pulse without one is an error.
    always @(negedge clk) begin
        bit seen_d, seen_od;
        logic [11:0] got;
        seen_d  = 1'b0;
        seen_od = 1'b0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                got = get_sig(q[i].sig);
                checks++;
                if (got !== q[i].val) begin
                    errors++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", q[i].nm, got, q[i].val, cyc);
                end
                if (q[i].sig == S_DONE)  seen_d  = 1'b1;
                if (q[i].sig == S_ODONE) seen_od = 1'b1;
                q.delete(i);
            end
        end
        if (done !== 1'b0 && !seen_d) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got %b expected 0 (cycle %0d)", done, cyc);
        end
        if (o_done !== 1'b0 && !seen_od) begin
            checks++;
            errors++;
            $display("FAIL unexpected_odd_done: got %b expected 0 (cycle %0d)", o_done, cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b1;
        step();
        exp_push(0, S_ACT,  12'd0, "rst_active");
        exp_push(0, S_BX,   12'd0, "rst_bird_x");
        exp_push(0, S_ON,   12'd0, "rst_bird_on");
        exp_push(0, S_DONE, 12'd0, "rst_done");
        exp_push(0, S_RA,   12'd0, "rst_rom_addr");
        exp_push(0, S_OACT, 12'd0, "rst_odd_active");
        step();
        rst = 1'b0;
        // Pixel inside the would-be window while idle: nothing drawn.
        pix_x = 10'd10; pix_y = 10'd305; rom_data = '1;
        exp_push(0, S_RA, 12'd0, "idle_rom_addr");
        exp_push(1, S_ON, 12'd0, "idle_bird_on");
        step();
        rom_data = '0; pix_x = '0; pix_y = '0;
        step();

        // Spawn
        run = 1'b1; spawn = 1'b1;
        exp_push(1, S_ACT, 12'd1,   "spawn_active");
        exp_push(1, S_BX,  12'd640, "spawn_bird_x");
        exp_push(1, S_OBX, 12'd643, "spawn_odd_bird_x");
        step();
        spawn = 1'b0;
        exp_x = 640; exp_ox = 643; n_mv = 0;

        // Eight ticks: animation frame flips (flap build), window edges
        tk(8);
        exp_push(0, S_BX, 12'd608, "tick8_bird_x");
        pix_x = 10'd608; pix_y = 10'd300;
        exp_push(0, S_RA, ra(8'h00), "tick8_rom_addr_topleft");
        step();
        pix_x = 10'd657; pix_y = 10'd338;
        exp_push(0, S_RA, ra(8'h26), "rom_addr_bottomright");
        step();
        pix_x = 10'd658;
        exp_push(0, S_RA, 12'd0, "rom_addr_right_out");
        step();
        pix_x = 10'd608; pix_y = 10'd339;
        exp_push(0, S_RA, 12'd0, "rom_addr_below_out");
        step();
        pix_y = 10'd299;
        exp_push(0, S_RA, 12'd0, "rom_addr_above_out");
        step();

        tk(2);
        exp_push(0, S_BX, 12'd600, "tick10_bird_x");
        tk(6);
        exp_push(0, S_BX, 12'd576, "tick16_bird_x");
        pix_x = 10'd576; pix_y = 10'd301;
        exp_push(0, S_RA, ra(8'h01), "tick16_rom_addr");
        step();

        // Freeze: run low with tick, spawn ignored
        run = 1'b0; tick = 1'b1; spawn = 1'b1;
        exp_push(1, S_BX,  12'd576, "freeze_tick_bird_x");
        exp_push(1, S_ACT, 12'd1,   "freeze_active");
        step();
        tick = 1'b0; spawn = 1'b0;
        step();
        tick = 1'b1;
        step();
        tick = 1'b0; spawn = 1'b1;
        step();
        spawn = 1'b0;
        exp_push(0, S_BX,  12'd576,        "freeze_hold_bird_x");
        exp_push(0, S_OBX, 12'(exp_ox),    "freeze_hold_odd_bird_x");
        run = 1'b1;
        step();
        step();
        exp_push(0, S_BX, 12'd576, "resume_no_move");
        tk(1);
        exp_push(0, S_BX, 12'd572, "resume_bird_x");

        // Pixel hit path at bird_x=100
        tk(118);
        exp_push(0, S_BX,  12'd100,       "bird_x_100");
        exp_push(0, S_OBX, 12'(exp_ox),   "odd_bird_x_103");
        pix_y = 10'd301; pix_x = 10'd122; rom_data = 50'd1 << 27;
        exp_push(0, S_RA, ra(8'h01), "hit_rom_addr");
        exp_push(1, S_ON, 12'd1,     "hit_bird_on");
        step();
        rom_data = 50'd1 << 26;
        exp_push(1, S_ON, 12'd0, "neighbour_bit_bird_on");
        step();
        pix_x = 10'd100; rom_data = 50'd1 << 49;
        exp_push(1, S_ON, 12'd1, "col0_msb_bird_on");
        step();
        pix_x = 10'd149; rom_data = 50'd1;
        exp_push(1, S_ON, 12'd1, "col49_lsb_bird_on");
        step();
        pix_x = 10'd150; rom_data = '1;
        exp_push(1, S_ON, 12'd0, "right_out_bird_on");
        step();
        pix_x = 10'd99;
        exp_push(1, S_ON, 12'd0, "left_out_bird_on");
        step();
        rom_data = '0; pix_x = '0; pix_y = '0;

        // Exit: main passes 4 -> 0 (still flying), odd reaches 3 then exits
        tk(24);
        exp_push(0, S_BX,  12'd4, "bird_x_4");
        exp_push(0, S_OBX, 12'd7, "odd_bird_x_7");
        tk(1);
        exp_push(0, S_BX,  12'd0, "bird_x_0_flying");
        exp_push(0, S_ACT, 12'd1, "bird_x_0_active");
        exp_push(0, S_OBX, 12'd3, "odd_bird_x_3");
        tick = 1'b1;
        exp_push(1, S_DONE,  12'd1, "exit_done");
        exp_push(1, S_ACT,   12'd0, "exit_active");
        exp_push(1, S_BX,    12'd0, "exit_bird_x");
        exp_push(1, S_ODONE, 12'd1, "odd_exit_done");
        exp_push(1, S_OACT,  12'd0, "odd_exit_active");
        exp_push(1, S_OBX,   12'd0, "odd_exit_bird_x");
        exp_push(2, S_DONE,  12'd0, "exit_done_one_cycle");
        exp_push(2, S_ODONE, 12'd0, "odd_exit_done_one_cycle");
        step();
        tick = 1'b0;
        step();
        step();

        // Spawn needs run; spawn beats a coincident tick
        run = 1'b0; spawn = 1'b1;
        exp_push(1, S_ACT, 12'd0, "spawn_no_run_active");
        step();
        spawn = 1'b0; run = 1'b1;
        step();
        spawn = 1'b1; tick = 1'b1;
        exp_push(1, S_BX,  12'd640, "spawn_tick_bird_x");
        exp_push(1, S_ACT, 12'd1,   "spawn_tick_active");
        step();
        spawn = 1'b0; tick = 1'b0;
        step();
        exp_x = 640; exp_ox = 643; n_mv = 0;
        tk(1);
        exp_push(0, S_BX, 12'd636, "respawn_tick_bird_x");

        // Reset mid-flight with the pixel flag set
        pix_x = 10'd636; pix_y = 10'd300; rom_data = 50'd1 << 49;
        exp_push(1, S_ON, 12'd1, "pre_rst_bird_on");
        step();
        step();
        rst = 1'b1;
        exp_push(0, S_ACT,  12'd0, "midrst_active");
        exp_push(0, S_BX,   12'd0, "midrst_bird_x");
        exp_push(0, S_ON,   12'd0, "midrst_bird_on");
        exp_push(0, S_OACT, 12'd0, "midrst_odd_active");
        exp_push(0, S_OBX,  12'd0, "midrst_odd_bird_x");
        step();
        rst = 1'b0; spawn = 1'b1; run = 1'b1;
        exp_push(1, S_ACT, 12'd1,   "post_rst_spawn_active");
        exp_push(1, S_BX,  12'd640, "post_rst_spawn_bird_x");
        step();
        spawn = 1'b0; rom_data = '0;
        repeat (4) step();

        if (q.size() != 0) begin
            errors += q.size();
            checks += q.size();
            $display("FAIL unchecked_expectations: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
